// File: rtl/sub_result_accumulator.sv
// Batch statistics stage behind an 8-bit subtracter: rebuilds signed 9-bit A-B
// differences, keeps a saturating sum and a borrow count over N_SAMPLES inputs.
module sub_result_accumulator #(
   parameter int N_SAMPLES = 8,
   parameter int ACC_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_diff,
   input  logic             in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] sum,
   output logic [7:0]       borrow_cnt,
   output logic             sat,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0]       LAST_IDX = 8'(N_SAMPLES - 1);
   localparam logic [ACC_W-1:0] SUM_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SUM_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

   state_t           state_reg, state_next;
   logic [ACC_W-1:0] sum_reg, sum_next;
   logic [7:0]       borrow_reg, borrow_next;
   logic [7:0]       count_reg, count_next;
   logic             sat_reg, sat_next;

   logic [ACC_W:0]   diff_ext;
   logic [ACC_W:0]   sum_wide;
   logic [ACC_W-1:0] sum_clamped;
   logic             overflow;

   // ~in_carry is the sign bit of the 9-bit difference; extend it one bit past ACC_W
   assign diff_ext = {{(ACC_W-8){~in_carry}}, ~in_carry, in_diff};
   assign sum_wide = {sum_reg[ACC_W-1], sum_reg} + diff_ext;
   assign overflow = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

   always_comb begin
      sum_clamped = sum_wide[ACC_W-1:0];
      if (overflow) begin
         sum_clamped = sum_wide[ACC_W] ? SUM_MIN : SUM_MAX;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         sum_reg    <= '0;
         borrow_reg <= '0;
         count_reg  <= '0;
         sat_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         sum_reg    <= sum_next;
         borrow_reg <= borrow_next;
         count_reg  <= count_next;
         sat_reg    <= sat_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      sum_next    = sum_reg;
      borrow_next = borrow_reg;
      count_next  = count_reg;
      sat_next    = sat_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               sum_next    = '0;
               borrow_next = '0;
               count_next  = '0;
               sat_next    = 1'b0;
               state_next  = ACCUM;
            end
         end
         ACCUM: begin
            // in_ready is constantly high here, so in_valid alone marks a transfer
            if (in_valid) begin
               sum_next    = sum_clamped;
               sat_next    = sat_reg | overflow;
               borrow_next = borrow_reg + {7'd0, ~in_carry};
               count_next  = count_reg + 8'd1;
               if (count_reg == LAST_IDX) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign in_ready   = (state_reg == ACCUM);
   assign out_valid  = (state_reg == DONE);
   assign busy       = (state_reg != IDLE);
   assign sum        = sum_reg;
   assign borrow_cnt = borrow_reg;
   assign sat        = sat_reg;

endmodule

// File: tb/tb_sub_result_accumulator.sv
// Directed and randomized batches on three parameterizations of
// sub_result_accumulator, checked against an arithmetic model of A-B batches.
module tb_sub_result_accumulator;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic in_valid = 1'b0;
   logic [7:0] in_diff = 8'd0;
   logic in_carry = 1'b0;
   logic out_ready = 1'b0;
   int   sel = 0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   // instance a: N=4, ACC_W=16; b: N=2, ACC_W=16; c: N=4, ACC_W=10
   logic start_a, start_b, start_c;
   assign start_a = start && (sel == 0);
   assign start_b = start && (sel == 1);
   assign start_c = start && (sel == 2);

   logic in_ready_a, out_valid_a, sat_a, busy_a;
   logic [15:0] sum_a;
   logic [7:0] borrow_a;
   logic in_ready_b, out_valid_b, sat_b, busy_b;
   logic [15:0] sum_b;
   logic [7:0] borrow_b;
   logic in_ready_c, out_valid_c, sat_c, busy_c;
   logic [9:0] sum_c;
   logic [7:0] borrow_c;

   sub_result_accumulator #(.N_SAMPLES(4), .ACC_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid),
      .in_ready(in_ready_a), .in_diff(in_diff), .in_carry(in_carry),
      .out_valid(out_valid_a), .out_ready(out_ready), .sum(sum_a),
      .borrow_cnt(borrow_a), .sat(sat_a), .busy(busy_a));

   sub_result_accumulator #(.N_SAMPLES(2), .ACC_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid),
      .in_ready(in_ready_b), .in_diff(in_diff), .in_carry(in_carry),
      .out_valid(out_valid_b), .out_ready(out_ready), .sum(sum_b),
      .borrow_cnt(borrow_b), .sat(sat_b), .busy(busy_b));

   sub_result_accumulator #(.N_SAMPLES(4), .ACC_W(10)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .in_valid(in_valid),
      .in_ready(in_ready_c), .in_diff(in_diff), .in_carry(in_carry),
      .out_valid(out_valid_c), .out_ready(out_ready), .sum(sum_c),
      .borrow_cnt(borrow_c), .sat(sat_c), .busy(busy_c));

   logic o_in_ready, o_out_valid, o_sat, o_busy;
   logic [31:0] o_sum;
   logic [7:0] o_borrow;

   always_comb begin
      o_in_ready  = in_ready_a;
      o_out_valid = out_valid_a;
      o_sat       = sat_a;
      o_busy      = busy_a;
      o_sum       = {{16{sum_a[15]}}, sum_a};
      o_borrow    = borrow_a;
      if (sel == 1) begin
         o_in_ready  = in_ready_b;
         o_out_valid = out_valid_b;
         o_sat       = sat_b;
         o_busy      = busy_b;
         o_sum       = {{16{sum_b[15]}}, sum_b};
         o_borrow    = borrow_b;
      end else if (sel == 2) begin
         o_in_ready  = in_ready_c;
         o_out_valid = out_valid_c;
         o_sat       = sat_c;
         o_busy      = busy_c;
         o_sum       = {{22{sum_c[9]}}, sum_c};
         o_borrow    = borrow_c;
      end
   end

   int samp_diff [16];
   int samp_carry [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
      end
   endtask

   // one batch: start, feed n samples (optionally with gaps and stray starts),
   // hold the result for hold cycles with out_ready low, then hand it off
   task automatic run_batch(input string name, input int k, input int n, input int accw,
                            input bit gaps, input int hold);
      int exp_sum = 0;
      int exp_borrow = 0;
      int exp_sat = 0;
      int max_v = (1 << (accw - 1)) - 1;
      int min_v = -(1 << (accw - 1));
      int sent = 0;
      int cyc = 0;
      int d;
      sel = k;
      chk({name, "_idle_busy"}, {31'd0, o_busy}, 32'd0);
      start = 1'b1;
      in_valid = 1'b1;
      in_diff = 8'($urandom);
      in_carry = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk({name, "_start_ready"}, {31'd0, o_in_ready}, 32'd1);
      chk({name, "_start_sum"}, o_sum, 32'd0);
      chk({name, "_start_borrow"}, {24'd0, o_borrow}, 32'd0);
      while (sent < n && cyc < 200) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_diff = 8'($urandom);
            in_carry = 1'($urandom);
         end else begin
            in_valid = 1'b1;
            in_diff = 8'(samp_diff[sent]);
            in_carry = 1'(samp_carry[sent]);
            d = (samp_carry[sent] != 0) ? samp_diff[sent] : samp_diff[sent] - 256;
            exp_sum = exp_sum + d;
            if (exp_sum > max_v) begin exp_sum = max_v; exp_sat = 1; end
            if (exp_sum < min_v) begin exp_sum = min_v; exp_sat = 1; end
            if (samp_carry[sent] == 0) exp_borrow++;
            sent++;
         end
         if (gaps && $urandom_range(0, 3) == 0) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (sent < n) begin
            chk({name, "_accum_outvalid"}, {31'd0, o_out_valid}, 32'd0);
         end
      end
      in_valid = 1'b0;
      if (cyc >= 200) chk({name, "_timeout"}, 32'd1, 32'd0);
      chk({name, "_done_valid"}, {31'd0, o_out_valid}, 32'd1);
      chk({name, "_done_inready"}, {31'd0, o_in_ready}, 32'd0);
      chk({name, "_sum"}, o_sum, exp_sum);
      chk({name, "_borrow"}, {24'd0, o_borrow}, exp_borrow);
      chk({name, "_sat"}, {31'd0, o_sat}, exp_sat);
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         start = (h == 0);
         in_valid = 1'b1;
         in_diff = 8'($urandom);
         in_carry = 1'($urandom);
         @(negedge clk);
         start = 1'b0;
         chk({name, "_hold_valid"}, {31'd0, o_out_valid}, 32'd1);
         chk({name, "_hold_sum"}, o_sum, exp_sum);
         chk({name, "_hold_borrow"}, {24'd0, o_borrow}, exp_borrow);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, "_ret_valid"}, {31'd0, o_out_valid}, 32'd0);
      chk({name, "_ret_busy"}, {31'd0, o_busy}, 32'd0);
      chk({name, "_ret_sum_kept"}, o_sum, exp_sum);
      $display("batch %s: inst=%0d n=%0d sum=%0d borrow=%0d sat=%0d cycles=%0d",
               name, k, n, exp_sum, exp_borrow, exp_sat, cyc);
   endtask

   task automatic set4(input int d0, input int c0, input int d1, input int c1,
                       input int d2, input int c2, input int d3, input int c3);
      samp_diff[0] = d0; samp_carry[0] = c0;
      samp_diff[1] = d1; samp_carry[1] = c1;
      samp_diff[2] = d2; samp_carry[2] = c2;
      samp_diff[3] = d3; samp_carry[3] = c3;
   endtask

   task automatic check_reset_zero(input string name);
      chk({name, "_inready"}, {31'd0, o_in_ready}, 32'd0);
      chk({name, "_outvalid"}, {31'd0, o_out_valid}, 32'd0);
      chk({name, "_sum"}, o_sum, 32'd0);
      chk({name, "_borrow"}, {24'd0, o_borrow}, 32'd0);
      chk({name, "_sat"}, {31'd0, o_sat}, 32'd0);
      chk({name, "_busy"}, {31'd0, o_busy}, 32'd0);
   endtask

   initial begin
      sel = 0;
      #12;
      check_reset_zero("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // reset mid-ACCUM after three samples
      sel = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_diff = 8'd50;
         in_carry = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("mid_busy", {31'd0, o_busy}, 32'd1);
      chk("mid_sum", o_sum, 32'd150);
      #2 rst_n = 1'b0;
      #1 check_reset_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset mid-batch applied and released");

      set4(7, 1, 249, 0, 100, 1, 156, 0);
      run_batch("basic", 0, 4, 16, 1'b0, 0);

      set4(0, 0, 255, 1, 0, 0, 0, 0);
      run_batch("extreme", 1, 2, 16, 1'b0, 0);

      set4(255, 1, 255, 1, 255, 1, 255, 1);
      run_batch("possat", 2, 4, 10, 1'b0, 0);

      set4(0, 0, 0, 0, 0, 0, 0, 0);
      run_batch("negsat", 2, 4, 10, 1'b0, 0);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 4; i++) begin
            samp_diff[i] = int'($urandom_range(0, 255));
            samp_carry[i] = int'($urandom_range(0, 1));
         end
         run_batch("stress", r % 3, (r % 3 == 1) ? 2 : 4, (r % 3 == 2) ? 10 : 16, 1'b1, 5);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
